// File: rtl/card_pkg.sv
// Shared card/segment definitions for the card display encoder and the readback decoder.
// Segment patterns are active-high, bit6=a ... bit0=g.
package card_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CARD_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [CARD_W-1:0] card_t;

    // Payload handed to the consumer for every completed decode
    typedef struct packed {
        card_t card;
        card_t value;
        logic  blank;
        logic  illegal;
    } card_result_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_ACE   = 7'b1110111;
    localparam seg_t SEG_TWO   = 7'b1101101;
    localparam seg_t SEG_THREE = 7'b1111001;
    localparam seg_t SEG_FOUR  = 7'b0110011;
    localparam seg_t SEG_FIVE  = 7'b1011011;
    localparam seg_t SEG_SIX   = 7'b1011111;
    localparam seg_t SEG_SEVEN = 7'b1110000;
    localparam seg_t SEG_EIGHT = 7'b1111111;
    localparam seg_t SEG_NINE  = 7'b1111011;
    localparam seg_t SEG_TEN   = 7'b1111110;
    localparam seg_t SEG_JACK  = 7'b0111100;
    localparam seg_t SEG_QUEEN = 7'b1110011;
    localparam seg_t SEG_KING  = 7'b0110111;

    localparam card_t CARD_BLANK   = 4'd0;
    localparam card_t CARD_ACE     = 4'd1;
    localparam card_t CARD_TWO     = 4'd2;
    localparam card_t CARD_THREE   = 4'd3;
    localparam card_t CARD_FOUR    = 4'd4;
    localparam card_t CARD_FIVE    = 4'd5;
    localparam card_t CARD_SIX     = 4'd6;
    localparam card_t CARD_SEVEN   = 4'd7;
    localparam card_t CARD_EIGHT   = 4'd8;
    localparam card_t CARD_NINE    = 4'd9;
    localparam card_t CARD_TEN     = 4'd10;
    localparam card_t CARD_JACK    = 4'd11;
    localparam card_t CARD_QUEEN   = 4'd12;
    localparam card_t CARD_KING    = 4'd13;
    localparam card_t CARD_ILLEGAL = 4'd15;

    localparam card_result_t RESULT_RESET = '{
        card:    CARD_BLANK,
        value:   4'd0,
        blank:   1'b1,
        illegal: 1'b0
    };

    // Inverse of the display encoder's card-to-segment map
    function automatic card_t seg_to_card(input seg_t seg);
        card_t c;
        c = CARD_ILLEGAL;
        case (seg)
            SEG_BLANK: c = CARD_BLANK;
            SEG_ACE:   c = CARD_ACE;
            SEG_TWO:   c = CARD_TWO;
            SEG_THREE: c = CARD_THREE;
            SEG_FOUR:  c = CARD_FOUR;
            SEG_FIVE:  c = CARD_FIVE;
            SEG_SIX:   c = CARD_SIX;
            SEG_SEVEN: c = CARD_SEVEN;
            SEG_EIGHT: c = CARD_EIGHT;
            SEG_NINE:  c = CARD_NINE;
            SEG_TEN:   c = CARD_TEN;
            SEG_JACK:  c = CARD_JACK;
            SEG_QUEEN: c = CARD_QUEEN;
            SEG_KING:  c = CARD_KING;
            default:   c = CARD_ILLEGAL;
        endcase
        return c;
    endfunction

    // Baccarat points: ace..nine count face value, tens/courts/blank/illegal count zero
    function automatic card_t card_value(input card_t c);
        card_t v;
        v = 4'd0;
        if (c >= CARD_ACE && c <= CARD_NINE) begin
            v = c;
        end
        return v;
    endfunction

    function automatic card_result_t decode_seg(input seg_t seg);
        card_result_t r;
        r.card    = seg_to_card(seg);
        r.value   = card_value(r.card);
        r.blank   = (r.card == CARD_BLANK);
        r.illegal = (r.card == CARD_ILLEGAL);
        return r;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Samples the segment bus and flags when it has held the same value for STABLE_CYCLES samples.
// stable_c is a level: it stays high for as long as the pattern keeps holding.
module seg_stable_filter
    import card_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetb,
    input  seg_t seg_in,
    output seg_t s_q,
    output logic stable_c
);

    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             same_c;

    assign same_c = (seg_in == s_q);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s_q   <= SEG_BLANK;
            cnt_q <= '0;
        end else begin
            s_q <= seg_in;
            if (!same_c) begin
                cnt_q <= '0;
            end else if (cnt_q < THRESH) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Asserted in the cycle whose edge brings the count to its threshold, and while saturated
    assign stable_c = same_c && (cnt_q >= THRESH_M1);

endmodule

// File: rtl/seg7card_decoder.sv
// Decodes a settled 7-segment card pattern back to card code and baccarat value,
// delivering one valid/ready transaction per distinct stable pattern.
module seg7card_decoder
    import card_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [SEG_W-1:0]  seg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CARD_W-1:0] card,
    output logic [CARD_W-1:0] value,
    output logic              blank,
    output logic              illegal
);

    typedef enum logic {
        SETTLE  = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t       state_q;
    seg_t         s_q;
    seg_t         last_rep_q;
    logic         stable_c;
    card_result_t res_q;
    logic         valid_q;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .resetb   (resetb),
        .seg_in   (seg_in),
        .s_q      (s_q),
        .stable_c (stable_c)
    );

    // Present a new result only when the settled pattern differs from the last one reported
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= SETTLE;
            valid_q    <= 1'b0;
            res_q      <= RESULT_RESET;
            last_rep_q <= SEG_BLANK;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (stable_c && (s_q != last_rep_q)) begin
                        res_q      <= decode_seg(s_q);
                        last_rep_q <= s_q;
                        valid_q    <= 1'b1;
                        state_q    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= SETTLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign card      = res_q.card;
    assign value     = res_q.value;
    assign blank     = res_q.blank;
    assign illegal   = res_q.illegal;

endmodule

// File: tb/tb_seg7card_decoder.sv
// Self-checking bench for seg7card_decoder: scenario tasks plus a scoreboard on accepted results.
module tb_seg7card_decoder;

    typedef struct packed {
        logic [3:0] card;
        logic [3:0] value;
        logic       blank;
        logic       illegal;
    } exp_t;

    logic       clk;
    logic       resetb;
    logic [6:0] seg_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] card;
    logic [3:0] value;
    logic       blank;
    logic       illegal;

    exp_t exp_q[$];
    exp_t exp_e;
    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;

    seg7card_decoder #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .seg_in    (seg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .card      (card),
        .value     (value),
        .blank     (blank),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake about to complete at the next rising edge pops one expectation
    always @(negedge clk) begin
        if (resetb === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_acc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got card=%0d value=%0d blank=%b illegal=%b, no transaction expected",
                         card, value, blank, illegal);
            end else begin
                exp_e = exp_q.pop_front();
                if (card !== exp_e.card || value !== exp_e.value ||
                    blank !== exp_e.blank || illegal !== exp_e.illegal) begin
                    errors++;
                    $display("FAIL scoreboard_data: got card=%0d value=%0d blank=%b illegal=%b, expected card=%0d value=%0d blank=%b illegal=%b",
                             card, value, blank, illegal, exp_e.card, exp_e.value, exp_e.blank, exp_e.illegal);
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] c, input logic [3:0] v, input logic b, input logic il);
        exp_t e;
        e.card    = c;
        e.value   = v;
        e.blank   = b;
        e.illegal = il;
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int valid_cycles;
        valid_cycles = 0;
        resetb    = 1'b0;
        seg_in    = 7'b0000000;
        out_ready = 1'b1;
        hold(2);
        checks++;
        if (out_valid !== 1'b0 || card !== 4'd0 || value !== 4'd0 || blank !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b card=%0d value=%0d blank=%b illegal=%b, expected 0/0/0/1/0",
                     out_valid, card, value, blank, illegal);
        end
        resetb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) valid_cycles++;
        end
        checks++;
        if (valid_cycles != 0) begin
            errors++;
            $display("FAIL reset_blank_quiet: out_valid high for %0d cycles, expected 0", valid_cycles);
        end
        checks++;
        if (card !== 4'd0 || blank !== 1'b1) begin
            errors++;
            $display("FAIL reset_blank_hold: got card=%0d blank=%b, expected card=0 blank=1", card, blank);
        end
    endtask

    task automatic test_latency_ace();
        push_exp(4'd1, 4'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        seg_in    = 7'b1110111;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== (k == 5)) begin
                errors++;
                $display("FAIL ace_latency edge %0d: got out_valid=%b, expected %b", k, out_valid, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (card !== 4'd1 || value !== 4'd1) begin
                    errors++;
                    $display("FAIL ace_outputs: got card=%0d value=%0d, expected card=1 value=1", card, value);
                end
            end
        end
    endtask

    task automatic test_sequence();
        int acc0;
        acc0 = n_acc;
        push_exp(4'd10, 4'd0, 1'b0, 1'b0);
        seg_in = 7'b1111110;
        hold(10);
        push_exp(4'd13, 4'd0, 1'b0, 1'b0);
        seg_in = 7'b0110111;
        hold(10);
        checks++;
        if (n_acc - acc0 != 2) begin
            errors++;
            $display("FAIL sequence_count: got %0d transactions, expected 2", n_acc - acc0);
        end
    endtask

    task automatic test_glitch();
        int acc0;
        acc0 = n_acc;
        push_exp(4'd9, 4'd9, 1'b0, 1'b0);
        seg_in = 7'b1111011;
        hold(10);
        seg_in = 7'b1111111;
        hold(2);
        seg_in = 7'b1111011;
        hold(12);
        checks++;
        if (n_acc - acc0 != 1) begin
            errors++;
            $display("FAIL glitch_count: got %0d transactions, expected 1", n_acc - acc0);
        end
    endtask

    task automatic test_stall();
        int waited;
        out_ready = 1'b0;
        push_exp(4'd5, 4'd5, 1'b0, 1'b0);
        seg_in = 7'b1011011;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            hold(1);
            waited++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_wait: out_valid=%b after %0d cycles, expected 1", out_valid, waited);
        end
        push_exp(4'd2, 4'd2, 1'b0, 1'b0);
        seg_in = 7'b1101101;
        for (int i = 0; i < 12; i++) begin
            hold(1);
            checks++;
            if (out_valid !== 1'b1 || card !== 4'd5 || value !== 4'd5) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%b card=%0d value=%0d, expected 1/5/5",
                         i, out_valid, card, value);
            end
        end
        out_ready = 1'b1;
        hold(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_gap: got out_valid=%b, expected 0", out_valid);
        end
        hold(1);
        checks++;
        if (out_valid !== 1'b1 || card !== 4'd2 || value !== 4'd2) begin
            errors++;
            $display("FAIL stall_next: got valid=%b card=%0d value=%0d, expected 1/2/2", out_valid, card, value);
        end
        hold(3);
    endtask

    task automatic test_illegal();
        int acc0;
        acc0 = n_acc;
        push_exp(4'd15, 4'd0, 1'b0, 1'b1);
        seg_in = 7'b1000000;
        for (int k = 1; k <= 10; k++) begin
            hold(1);
            if (k == 5) begin
                checks++;
                if (out_valid !== 1'b1 || card !== 4'd15 || illegal !== 1'b1 || value !== 4'd0 || blank !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_outputs: got valid=%b card=%0d value=%0d blank=%b illegal=%b, expected 1/15/0/0/1",
                             out_valid, card, value, blank, illegal);
                end
            end
        end
        checks++;
        if (n_acc - acc0 != 1) begin
            errors++;
            $display("FAIL illegal_count: got %0d transactions, expected 1", n_acc - acc0);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        int acc0;
        int valid_cycles;
        out_ready = 1'b0;
        seg_in    = 7'b1111001;
        waited    = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            hold(1);
            waited++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: out_valid=%b after %0d cycles, expected 1", out_valid, waited);
        end
        resetb = 1'b0;
        seg_in = 7'b0000000;
        #1;
        checks++;
        if (out_valid !== 1'b0 || card !== 4'd0 || blank !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: got valid=%b card=%0d blank=%b, expected 0/0/1", out_valid, card, blank);
        end
        hold(1);
        resetb       = 1'b1;
        out_ready    = 1'b1;
        acc0         = n_acc;
        valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            hold(1);
            if (out_valid === 1'b1) valid_cycles++;
        end
        checks++;
        if (valid_cycles != 0 || n_acc != acc0) begin
            errors++;
            $display("FAIL reset_mid_dropped: valid cycles=%0d transactions=%0d, expected 0 and 0",
                     valid_cycles, n_acc - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_latency_ace();
        test_sequence();
        test_glitch();
        test_stall();
        test_illegal();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expected transactions never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
